stateful_mac_array: RTL and testbench

Parametrised successor to the single-register stateful MAC atom. Holds NUM_SLOTS independent state registers, each selected per packet by an index field, and applies new = mux(state,0,sel1) * mux(constant,pkt_1,sel2) + mux(pkt_2,pkt_3,sel3) to the selected slot. Three-stage pipeline with a valid qualifier and internal forwarding so back-to-back packets to the same slot behave as if serialised. Sits in the stateful-atom stage of the packet-transaction pipeline.

---
 rtl/stateful_mac_pkg.sv | 13 +
 rtl/mac_slot_bank.sv | 41 ++++
 rtl/stateful_mac_array.sv | 186 ++++++++++++++++++
 tb/tb_stateful_mac_array.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stateful_mac_pkg.sv
// Shared constants and helpers for the stateful MAC slot array.
// The default slot count is deliberately a power of two; any count is legal.
package stateful_mac_pkg;

   localparam int MAC_COUNT_WIDTH = 32;
   localparam int MAC_NUM_SLOTS = 16;

   // The slot index is never narrower than one bit, even for one slot.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_slot_bank.sv
// Slot register file: one combinational read port and one clocked write port.
// Out-of-range reads return zero and out-of-range writes are dropped.
module mac_slot_bank
   import stateful_mac_pkg::*;
#(
   parameter int COUNT_WIDTH = MAC_COUNT_WIDTH,
   parameter int NUM_SLOTS = MAC_NUM_SLOTS,
   parameter int IDX_WIDTH = idx_width(NUM_SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IDX_WIDTH-1:0]   rd_idx,
   output logic [COUNT_WIDTH-1:0] rd_data,
   input  logic                   wr_en,
   input  logic [IDX_WIDTH-1:0]   wr_idx,
   input  logic [COUNT_WIDTH-1:0] wr_data
);

   localparam logic [IDX_WIDTH:0] LIMIT =
      (IDX_WIDTH+1)'(NUM_SLOTS);

   logic [COUNT_WIDTH-1:0] mem [NUM_SLOTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && ({1'b0, wr_idx} < LIMIT)) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_idx} < LIMIT) begin
         rd_data = mem[rd_idx];
      end
   end

endmodule

// File: rtl/stateful_mac_array.sv
// Multi-slot stateful MAC: slot = mux(state,0)*mux(const,pkt_1)+mux(pkt_2,pkt_3).
// Three pipeline stages with S3->S2 forwarding. Define MAC_SAT_EN for clamping.
module stateful_mac_array
   import stateful_mac_pkg::*;
#(
   parameter int COUNT_WIDTH = MAC_COUNT_WIDTH,
   parameter int NUM_SLOTS = MAC_NUM_SLOTS,
   parameter int IDX_WIDTH = idx_width(NUM_SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i__valid,
   input  logic [IDX_WIDTH-1:0]   i__index,
   input  logic [COUNT_WIDTH-1:0] i__constant,
   input  logic [COUNT_WIDTH-1:0] i__pkt_1,
   input  logic [COUNT_WIDTH-1:0] i__pkt_2,
   input  logic [COUNT_WIDTH-1:0] i__pkt_3,
   input  logic                   i__sel1,
   input  logic                   i__sel2,
   input  logic                   i__sel3,
   output logic                   o__valid,
`ifdef MAC_SAT_EN
   output logic                   o__sat,
`endif
   output logic [IDX_WIDTH-1:0]   o__index,
   output logic [COUNT_WIDTH-1:0] o__read,
   output logic [COUNT_WIDTH-1:0] o__write,
   output logic                   o__oob
);

   localparam int W = COUNT_WIDTH;
   localparam logic [IDX_WIDTH:0] LIMIT =
      (IDX_WIDTH+1)'(NUM_SLOTS);

   typedef struct packed {
      logic                 valid;
      logic                 oob;
      logic [IDX_WIDTH-1:0] idx;
      logic [W-1:0]         state;
      logic [W-1:0]         product;
      logic [W-1:0]         addend;
`ifdef MAC_SAT_EN
      logic                 ovf;
`endif
   } pipe_t;

   logic                 s1_valid;
   logic [IDX_WIDTH-1:0] s1_idx;
   logic [W-1:0]         s1_const;
   logic [W-1:0]         s1_pkt_1;
   logic [W-1:0]         s1_pkt_2;
   logic [W-1:0]         s1_pkt_3;
   logic                 s1_sel1;
   logic                 s1_sel2;
   logic                 s1_sel3;

   pipe_t p2;

   logic         s1_oob;
   logic         fwd_hit;
   logic [W-1:0] bank_rd;
   logic [W-1:0] cur_state;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] prod;
   logic [W-1:0] res;
   logic         wr_en;
   logic         sat_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_const <= '0;
         s1_pkt_1 <= '0;
         s1_pkt_2 <= '0;
         s1_pkt_3 <= '0;
         s1_sel1  <= 1'b0;
         s1_sel2  <= 1'b0;
         s1_sel3  <= 1'b0;
      end else begin
         s1_valid <= i__valid;
         s1_idx   <= i__index;
         s1_const <= i__constant;
         s1_pkt_1 <= i__pkt_1;
         s1_pkt_2 <= i__pkt_2;
         s1_pkt_3 <= i__pkt_3;
         s1_sel1  <= i__sel1;
         s1_sel2  <= i__sel2;
         s1_sel3  <= i__sel3;
      end
   end

   mac_slot_bank #(
      .COUNT_WIDTH (W),
      .NUM_SLOTS   (NUM_SLOTS),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (s1_idx),
      .rd_data (bank_rd),
      .wr_en   (wr_en),
      .wr_idx  (p2.idx),
      .wr_data (res)
   );

   // The S3 result is not yet in the bank, so a same-slot read takes it here.
   always_comb begin
      s1_oob    = ({1'b0, s1_idx} >= LIMIT);
      fwd_hit   = p2.valid && !p2.oob &&
                  (p2.idx == s1_idx);
      cur_state = bank_rd;
      if (s1_oob) begin
         cur_state = '0;
      end else if (fwd_hit) begin
         cur_state = res;
      end
      op_a = s1_sel1 ? '0 : cur_state;
      op_b = s1_sel2 ? s1_pkt_1 : s1_const;
   end

`ifdef MAC_SAT_EN
   logic [2*W-1:0] prod_full;
   logic [W:0]     sum_full;

   assign prod_full = {{W{1'b0}}, op_a} *
                      {{W{1'b0}}, op_b};
   assign prod      = prod_full[W-1:0];
   assign sum_full  = {1'b0, p2.product} +
                      {1'b0, p2.addend};
   assign sat_hit   = p2.ovf | sum_full[W];
   assign res       = sat_hit ? '1 : sum_full[W-1:0];
`else
   assign prod    = op_a * op_b;
   assign res     = p2.product + p2.addend;
   assign sat_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p2 <= '0;
      end else begin
         p2.valid   <= s1_valid;
         p2.oob     <= s1_oob;
         p2.idx     <= s1_idx;
         p2.state   <= cur_state;
         p2.product <= prod;
         p2.addend  <= s1_sel3 ? s1_pkt_3 : s1_pkt_2;
`ifdef MAC_SAT_EN
         p2.ovf     <= |prod_full[2*W-1:W];
`endif
      end
   end

   assign wr_en = p2.valid && !p2.oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o__valid <= 1'b0;
         o__oob   <= 1'b0;
         o__index <= '0;
         o__read  <= '0;
         o__write <= '0;
      end else begin
         o__valid <= p2.valid;
         o__oob   <= p2.valid && p2.oob;
         if (p2.valid) begin
            o__index <= p2.idx;
            o__read  <= p2.oob ? '0 : p2.state;
            o__write <= p2.oob ? '0 : res;
         end
      end
   end

`ifdef MAC_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o__sat <= 1'b0;
      end else begin
         o__sat <= wr_en && sat_hit;
      end
   end
`endif

endmodule

// File: tb/tb_stateful_mac_array.sv
// Scoreboard bench for stateful_mac_array with NUM_SLOTS=12.
// Expected results come from a one-packet-at-a-time reference model.
module tb_stateful_mac_array;

   localparam int W  = 32;
   localparam int N  = 12;
   localparam int IW = 4;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  rd;
      logic [W-1:0]  wr;
      logic          oob;
      logic          sat;
      logic [15:0]   cyc;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i__valid = 1'b0;
   logic [IW-1:0] i__index = '0;
   logic [W-1:0]  i__constant = '0;
   logic [W-1:0]  i__pkt_1 = '0;
   logic [W-1:0]  i__pkt_2 = '0;
   logic [W-1:0]  i__pkt_3 = '0;
   logic          i__sel1 = 1'b0;
   logic          i__sel2 = 1'b0;
   logic          i__sel3 = 1'b0;
   logic          o__valid;
   logic          o__sat;
   logic [IW-1:0] o__index;
   logic [W-1:0]  o__read;
   logic [W-1:0]  o__write;
   logic          o__oob;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   res_t exp_q[$];
   res_t obs_q[$];
   logic [W-1:0] ref_mem [N];

`ifndef MAC_SAT_EN
   assign o__sat = 1'b0;
`endif

   stateful_mac_array #(
      .COUNT_WIDTH (W),
      .NUM_SLOTS   (N),
      .IDX_WIDTH   (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i__valid    (i__valid),
      .i__index    (i__index),
      .i__constant (i__constant),
      .i__pkt_1    (i__pkt_1),
      .i__pkt_2    (i__pkt_2),
      .i__pkt_3    (i__pkt_3),
      .i__sel1     (i__sel1),
      .i__sel2     (i__sel2),
      .i__sel3     (i__sel3),
      .o__valid    (o__valid),
`ifdef MAC_SAT_EN
      .o__sat      (o__sat),
`endif
      .o__index    (o__index),
      .o__read     (o__read),
      .o__write    (o__write),
      .o__oob      (o__oob)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o__valid === 1'b1) begin
         obs_q.push_back('{o__index, o__read, o__write,
                           o__oob, o__sat, 16'(cyc)});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not end, time %0t", $time);
      $fatal(1);
   end

   task automatic push_exp(input logic [IW-1:0] idx,
                           input logic [W-1:0] c, p1, p2, p3,
                           input logic s1, s2, s3);
      logic [W-1:0]   st, a, b, ad;
      logic [2*W:0]   full;
      res_t           e;
      e = '0;
      e.idx = idx;
      e.cyc = 16'(cyc + 3);
      if (int'(idx) >= N) begin
         e.oob = 1'b1;
      end else begin
         st = ref_mem[idx];
         a  = s1 ? '0 : st;
         b  = s2 ? p1 : c;
         ad = s3 ? p3 : p2;
         full = (2*W+1)'(a) * (2*W+1)'(b) + (2*W+1)'(ad);
`ifdef MAC_SAT_EN
         if (full > (2*W+1)'({W{1'b1}})) begin
            e.wr  = '1;
            e.sat = 1'b1;
         end else begin
            e.wr = full[W-1:0];
         end
`else
         e.wr = full[W-1:0];
`endif
         e.rd = st;
         ref_mem[idx] = e.wr;
      end
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [IW-1:0] idx,
                       input logic [W-1:0] c, p1, p2, p3,
                       input logic s1, s2, s3);
      @(negedge clk);
      i__valid = 1'b1;
      i__index = idx;
      i__constant = c;
      i__pkt_1 = p1;
      i__pkt_2 = p2;
      i__pkt_3 = p3;
      i__sel1 = s1;
      i__sel2 = s2;
      i__sel3 = s3;
      push_exp(idx, c, p1, p2, p3, s1, s2, s3);
   endtask

   task automatic drain();
      @(negedge clk);
      i__valid = 1'b0;
      for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) begin
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      #3;
      checks++;
      if ({o__valid, o__oob, o__index, o__read, o__write} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b oob=%b idx=%0d rd=%h wr=%h, want all 0",
                  o__valid, o__oob, o__index, o__read, o__write);
      end
      checks++;
      if (o__sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_sat: got %b want 0", o__sat);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (o__valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid: got %b want 0", o__valid);
      end
   endtask

   task automatic test_single();
      res_t e, o;
      send(4'd3, 32'd2, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL single: got idx=%0d rd=%h wr=%h oob=%b sat=%b cyc=%0d want idx=%0d rd=%h wr=%h oob=%b sat=%b cyc=%0d",
                     o.idx, o.rd, o.wr, o.oob, o.sat, o.cyc, e.idx, e.rd, e.wr, e.oob, e.sat, e.cyc);
         end
         checks++;
         if (o.wr !== 32'd5) begin
            errors++;
            $display("FAIL single_write: got %0d want 5", o.wr);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL single_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      res_t e, o;
      logic [W-1:0] lit [3];
      lit[0] = 32'd15;
      lit[1] = 32'd35;
      lit[2] = 32'd75;
      repeat (3) send(4'd3, 32'd2, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b: got idx=%0d rd=%h wr=%h oob=%b cyc=%0d want idx=%0d rd=%h wr=%h oob=%b cyc=%0d",
                     o.idx, o.rd, o.wr, o.oob, o.cyc, e.idx, e.rd, e.wr, e.oob, e.cyc);
         end
         checks++;
         if (o.wr !== lit[i]) begin
            errors++;
            $display("FAIL b2b_write%0d: got %0d want %0d", i, o.wr, lit[i]);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_alternate();
      res_t e, o;
      for (int i = 0; i < 4; i++) begin
         send((i % 2 == 0) ? 4'd1 : 4'd2, 32'd1, 32'd0, 32'd1, 32'd0,
              1'b0, 1'b0, 1'b0);
      end
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL alternate: got idx=%0d rd=%h wr=%h cyc=%0d want idx=%0d rd=%h wr=%h cyc=%0d",
                     o.idx, o.rd, o.wr, o.cyc, e.idx, e.rd, e.wr, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL alternate_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_oob();
      res_t e, o;
      send(4'd13, 32'd7, 32'd1, 32'd9, 32'd4, 1'b0, 1'b1, 1'b1);
      send(4'd12, 32'd7, 32'd1, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0);
      send(4'd15, 32'd7, 32'd1, 32'd9, 32'd4, 1'b1, 1'b0, 1'b0);
      send(4'd11, 32'd3, 32'd0, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd3, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL oob: got idx=%0d rd=%h wr=%h oob=%b cyc=%0d want idx=%0d rd=%h wr=%h oob=%b cyc=%0d",
                     o.idx, o.rd, o.wr, o.oob, o.cyc, e.idx, e.rd, e.wr, e.oob, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL oob_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_wrap();
      res_t e, o;
      send(4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
      send(4'd5, 32'd2, 32'd0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd5, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd6, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
           1'b1, 1'b1, 1'b1);
      send(4'd6, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1, 1'b1);
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap: got idx=%0d rd=%h wr=%h sat=%b cyc=%0d want idx=%0d rd=%h wr=%h sat=%b cyc=%0d",
                     o.idx, o.rd, o.wr, o.sat, o.cyc, e.idx, e.rd, e.wr, e.sat, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_random();
      res_t e, o;
      logic [IW-1:0] idx;
      logic [W-1:0]  v [4];
      for (int n = 0; n < 60; n++) begin
         idx = ($urandom_range(0, 5) == 0) ?
               IW'($urandom_range(8, 15)) : IW'($urandom_range(0, 3));
         for (int j = 0; j < 4; j++) begin
            v[j] = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            i__valid = 1'b0;
         end
         send(idx, v[0], v[1], v[2], v[3], 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL random: got idx=%0d rd=%h wr=%h oob=%b sat=%b cyc=%0d want idx=%0d rd=%h wr=%h oob=%b sat=%b cyc=%0d",
                     o.idx, o.rd, o.wr, o.oob, o.sat, o.cyc, e.idx, e.rd, e.wr, e.oob, e.sat, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL random_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid_burst();
      res_t e, o;
      send(4'd7, 32'd0, 32'd0, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
      send(4'd7, 32'd1, 32'd0, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd8, 32'd0, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      i__valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      #1;
      checks++;
      if ({o__valid, o__oob, o__index, o__read, o__write, o__sat} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got v=%b oob=%b idx=%0d rd=%h wr=%h sat=%b, want all 0",
                  o__valid, o__oob, o__index, o__read, o__write, o__sat);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_flush: got %0d outputs want 0", obs_q.size());
         obs_q.delete();
      end
      send(4'd7, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd8, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd3, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      send(4'd5, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL midreset_read: got idx=%0d rd=%h wr=%h cyc=%0d want idx=%0d rd=%h wr=%h cyc=%0d",
                     o.idx, o.rd, o.wr, o.cyc, e.idx, e.rd, e.wr, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_extra: got %0d extra outputs want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_alternate();
      test_oob();
      test_wrap();
      test_random();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
